key_pulse_gen: RTL
==================

Name: key_pulse_gen

Overview:
- Multi-channel successor to the single-input level-to-pulse converter used on the lock keypad path.
- Each channel synchronises an asynchronous key level, debounces it and emits one-cycle press and release pulses.
- Optional per-channel auto-repeat while a key is held.
- Sits between the raw keypad/switch inputs and the lock's code-entry FSM.

Parameters:
CHANNELS, 4, number of independent key inputs
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 4, consecutive equal synchronised samples needed to accept a level change (>=2)
REPEAT_DELAY, 16, cycles from a press pulse to the first auto-repeat pulse (>=2)
REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (>=2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
lvl  input  CHANNELS  raw key levels, asynchronous to clk
repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clk
press_pulse  output  CHANNELS  one-cycle pulse per accepted press or auto-repeat
release_pulse  output  CHANNELS  one-cycle pulse per accepted release
level_db  output  CHANNELS  debounced level
any_press  output  1  OR of press_pulse

Behaviour:
- Reset:
  - While reset_n=0, all sync flops, states and counters clear asynchronously.
  - press_pulse, release_pulse, level_db and any_press are 0 during reset.
- Synchroniser: s = lvl after SYNC_STAGES flops. The FSM samples s.
- Per-channel state and counter:
  - States: IDLE, PRESS_DB, HELD, REPEAT, REL_DB.
  - One counter of width clog2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- Transitions (evaluated at each clk edge):
  - IDLE: s=1 -> PRESS_DB, cnt=1.
  - PRESS_DB:
    - s=0 -> IDLE, no pulse (glitch rejected).
    - s=1 and cnt==DB_CYCLES-1 -> HELD, cnt=0, press_pulse=1.
    - Otherwise cnt++.
  - HELD:
    - s=0 -> REL_DB, cnt=1.
    - s=1, repeat_en=1 and cnt==REPEAT_DELAY-1 -> REPEAT, cnt=0, press_pulse=1.
    - Otherwise cnt++, saturating at REPEAT_DELAY-1.
  - REPEAT:
    - s=0 -> REL_DB, cnt=1.
    - repeat_en=0 -> HELD, cnt=0.
    - cnt==REPEAT_PERIOD-1 -> press_pulse=1, cnt=0.
    - Otherwise cnt++.
  - REL_DB:
    - s=1 -> HELD, cnt=0, no pulse (release bounce rejected).
    - s=0 and cnt==DB_CYCLES-1 -> IDLE, release_pulse=1.
    - Otherwise cnt++.
- Outputs:
  - level_db=1 in HELD, REPEAT and REL_DB.
  - level_db is registered and changes in the same cycle as press_pulse or release_pulse.
  - press_pulse and release_pulse are registered and high for exactly one cycle.
  - any_press is combinational from the registered press_pulse vector.
- Latency: a lvl change settled before edge X gives a pulse in the cycle after edge X+SYNC_STAGES+DB_CYCLES-1 (X+5 with defaults).
- Saturated HELD: if repeat_en is asserted after saturation, the repeat pulse fires on the next edge.
- Reset release with lvl held high is treated as a fresh press: normal latency, pulse issued.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.

Decomposition:
- Package key_pulse_pkg holds the state enum (IDLE, PRESS_DB, HELD, REPEAT, REL_DB) and the counter-width function.
- Sub-module key_pulse_chan implements one channel: synchroniser, FSM and counter.
- key_pulse_gen generate-instantiates CHANNELS copies and forms any_press.

Test Plan:
1. Defaults, repeat_en=0; lvl[0] rises before edge 1 and is held 20 cycles -> press_pulse[0] high only after edge 6; level_db[0] rises after edge 6; no other pulses.
2. lvl[1] high for 3 cycles only -> no press_pulse[1]; level_db[1] stays 0.
3. After an accepted press, lvl[0] low 2 cycles, high 1, then low and stable from before edge 40 -> no pulse from the bounce; release_pulse[0] only after edge 45; level_db[0] falls after edge 45.
4. repeat_en[2]=1; lvl[2] high before edges 1..36, low before edge 37 -> press_pulse[2] after edges 6, 22, 26, 30, 34, 38; release_pulse[2] after edge 42.
5. lvl[3] held high, reset_n pulsed low mid-HELD -> all outputs 0 immediately; reset_n released so edge 50 is the first active edge -> press_pulse[3] after edge 55.
6. lvl[0] and lvl[3] rise in the same cycle -> both press_pulse bits high in the same cycle; any_press high for that one cycle only.

Source files
------------

// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg
//   Shared definitions for the key pulse generator:
//   - state_t   : per-channel debounce / repeat FSM states
//   - cnt_width : width of the per-channel counter, sized so that the
//                 largest terminal count (debounce, repeat delay or repeat
//                 period) fits.
package key_pulse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  // clog2(max(a, b, c) + 1)
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_pulse_chan.sv
// key_pulse_chan
//   One key channel: synchroniser, debounce/repeat FSM and shared counter.
//   Ports:
//     clk           in   system clock, rising edge
//     reset_n       in   asynchronous active-low reset
//     lvl           in   raw key level, asynchronous to clk
//     repeat_en     in   auto-repeat enable, synchronous to clk
//     press_pulse   out  one-cycle pulse per accepted press or auto-repeat
//     release_pulse out  one-cycle pulse per accepted release
//     level_db      out  debounced level
module key_pulse_chan
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lvl,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic level_db
);

  localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(REPEAT_PERIOD - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser: lvl shifts in at bit 0, the FSM looks at the top bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], lvl};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM and counter
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            press_reg, press_next;
  logic            release_reg, release_next;
  logic            level_reg, level_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (s) begin
          state_next = PRESS_DB;
          cnt_next   = CNT_ONE;
        end
      end

      PRESS_DB: begin
        if (!s) begin
          // Glitch shorter than the debounce window: drop it silently.
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == DB_LAST) begin
          state_next = HELD;
          cnt_next   = CNT_ZERO;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HELD: begin
        if (!s) begin
          state_next = REL_DB;
          cnt_next   = CNT_ONE;
        end else if (repeat_en && (cnt_reg == DLY_LAST)) begin
          state_next = REPEAT;
          cnt_next   = CNT_ZERO;
          press_next = 1'b1;
        end else if (cnt_reg != DLY_LAST) begin
          // Saturate so a late repeat_en fires on the very next edge.
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      REPEAT: begin
        if (!s) begin
          state_next = REL_DB;
          cnt_next   = CNT_ONE;
        end else if (!repeat_en) begin
          state_next = HELD;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == PER_LAST) begin
          cnt_next   = CNT_ZERO;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      REL_DB: begin
        if (s) begin
          // Release bounce: key is still considered held.
          state_next = HELD;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == DB_LAST) begin
          state_next   = IDLE;
          cnt_next     = CNT_ZERO;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Debounced level follows the next state so it moves in the same cycle
  // as the corresponding press/release pulse.
  always_comb begin
    level_next = (state_next == HELD) || (state_next == REPEAT) ||
                 (state_next == REL_DB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= CNT_ZERO;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      level_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      level_reg   <= level_next;
    end
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign level_db      = level_reg;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Multi-channel key level to press/release pulse converter with debounce
//   and optional per-channel auto-repeat.
//   Ports:
//     clk           in   system clock, rising edge
//     reset_n       in   asynchronous active-low reset
//     lvl           in   [CHANNELS] raw key levels, asynchronous to clk
//     repeat_en     in   [CHANNELS] per-channel auto-repeat enable
//     press_pulse   out  [CHANNELS] one-cycle press / auto-repeat pulses
//     release_pulse out  [CHANNELS] one-cycle release pulses
//     level_db      out  [CHANNELS] debounced levels
//     any_press     out  OR of press_pulse
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] lvl,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] level_db,
  output logic                any_press
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      key_pulse_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_chan (
        .clk          (clk),
        .reset_n      (reset_n),
        .lvl          (lvl[gi]),
        .repeat_en    (repeat_en[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi]),
        .level_db     (level_db[gi])
      );
    end
  endgenerate

  // Built from the registered pulses, so any_press is glitch-free.
  assign any_press = |press_pulse;

endmodule
